// File: rtl/axis_frame_painter.sv
// Purpose : on start, streams a full frame of pixel writes: background clear, X axis, Y axis,
//           then tick marks on both axes. Geometry and colours are parametrised or latched on start.
// Latency : first pixel presented the cycle after start is accepted; one pixel per cycle while
//           pix_ready=1; done rises the cycle after the last pixel handshake.
// Backpressure: pix_valid/pix_ready handshake; the pixel is held stable while pix_ready=0.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   start               begin a frame (accepted only when idle or done)
//   x_center, y_center  column of the Y axis / row of the X axis (latched on start)
//   bg_col, axis_col    clear colour / axis and tick colour (latched on start)
//   pix_valid/pix_ready pixel write handshake; pix_x, pix_y, pix_col carry the pixel
//   busy, done          frame in progress / frame finished (held until next start or reset)
module axis_frame_painter #(
    parameter int H_RES        = 320,
    parameter int V_RES        = 240,
    parameter int X_W          = 9,
    parameter int Y_W          = 8,
    parameter int COL_W        = 6,
    parameter int TICK_SPACING = 10,
    parameter int TICK_HALF    = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [X_W-1:0]   x_center,
    input  logic [Y_W-1:0]   y_center,
    input  logic [COL_W-1:0] bg_col,
    input  logic [COL_W-1:0] axis_col,
    output logic             pix_valid,
    input  logic             pix_ready,
    output logic [X_W-1:0]   pix_x,
    output logic [Y_W-1:0]   pix_y,
    output logic [COL_W-1:0] pix_col,
    output logic             busy,
    output logic             done
);

    // Two extra bits give room for a sign and for centre + spacing without wrap-around.
    localparam int XS = X_W + 2;
    localparam int YS = Y_W + 2;

    localparam logic signed [XS-1:0] H_S    = XS'(H_RES);
    localparam logic signed [XS-1:0] H_MAXS = XS'(H_RES - 1);
    localparam logic signed [XS-1:0] SX     = XS'(TICK_SPACING);
    localparam logic signed [XS-1:0] TX     = XS'(TICK_HALF);
    localparam logic signed [XS-1:0] X_ZERO = '0;
    localparam logic signed [YS-1:0] V_S    = YS'(V_RES);
    localparam logic signed [YS-1:0] V_MAXS = YS'(V_RES - 1);
    localparam logic signed [YS-1:0] SY     = YS'(TICK_SPACING);
    localparam logic signed [YS-1:0] TY     = YS'(TICK_HALF);
    localparam logic signed [YS-1:0] Y_ZERO = '0;
    localparam logic [X_W-1:0]       X_LAST = X_W'(H_RES - 1);
    localparam logic [Y_W-1:0]       Y_LAST = Y_W'(V_RES - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_XAXIS, S_YAXIS, S_XTICK, S_YTICK, S_DONE
    } state_t;

    state_t           state;
    logic [X_W-1:0]   xc_r;
    logic [Y_W-1:0]   yc_r;
    logic [COL_W-1:0] bg_r;
    logic [COL_W-1:0] axis_r;
    // Set while walking the ticks on the negative side of the centre.
    logic             tick_neg;

    // ---------------------------------------------------------------
    // Geometry derived from the latched centre
    // ---------------------------------------------------------------
    logic signed [XS-1:0] xc_s, px_s, px_p, px_m, xt_pos, xt_neg, c_lo_s, c_hi_s;
    logic signed [YS-1:0] yc_s, py_s, py_p, py_m, yt_pos, yt_neg, r_lo_s, r_hi_s;
    logic                 x_on, y_on, ticks_on;
    logic                 xt_pos_ok, xt_neg_ok, yt_pos_ok, yt_neg_ok;
    logic                 px_p_ok, px_m_ok, py_p_ok, py_m_ok;
    logic [Y_W-1:0]       xt_row_lo, xt_row_hi;
    logic [X_W-1:0]       yt_col_lo, yt_col_hi;

    assign xc_s   = {2'b00, xc_r};
    assign yc_s   = {2'b00, yc_r};
    assign px_s   = {2'b00, pix_x};
    assign py_s   = {2'b00, pix_y};

    assign x_on     = (xc_s < H_S);
    assign y_on     = (yc_s < V_S);
    assign ticks_on = x_on && y_on;

    // First tick on each side of the centre.
    assign xt_pos    = xc_s + SX;
    assign xt_neg    = xc_s - SX;
    assign yt_pos    = yc_s + SY;
    assign yt_neg    = yc_s - SY;
    assign xt_pos_ok = (xt_pos < H_S);
    assign xt_neg_ok = (xt_neg >= X_ZERO);
    assign yt_pos_ok = (yt_pos < V_S);
    assign yt_neg_ok = (yt_neg >= Y_ZERO);

    // Next tick from the current pixel position.
    assign px_p    = px_s + SX;
    assign px_m    = px_s - SX;
    assign py_p    = py_s + SY;
    assign py_m    = py_s - SY;
    assign px_p_ok = (px_p < H_S);
    assign px_m_ok = (px_m >= X_ZERO);
    assign py_p_ok = (py_p < V_S);
    assign py_m_ok = (py_m >= Y_ZERO);

    // Clipped perpendicular extent of a tick. The centre itself lies on screen whenever
    // ticks are drawn, so each range holds at least one pixel.
    assign r_lo_s    = yc_s - TY;
    assign r_hi_s    = yc_s + TY;
    assign c_lo_s    = xc_s - TX;
    assign c_hi_s    = xc_s + TX;
    assign xt_row_lo = (r_lo_s < Y_ZERO) ? '0     : r_lo_s[Y_W-1:0];
    assign xt_row_hi = (r_hi_s > V_MAXS) ? Y_LAST : r_hi_s[Y_W-1:0];
    assign yt_col_lo = (c_lo_s < X_ZERO) ? '0     : c_lo_s[X_W-1:0];
    assign yt_col_hi = (c_hi_s > H_MAXS) ? X_LAST : c_hi_s[X_W-1:0];

    // ---------------------------------------------------------------
    // Step within the current phase
    // ---------------------------------------------------------------
    logic           adv_vld;
    logic [X_W-1:0] adv_x;
    logic [Y_W-1:0] adv_y;
    logic           adv_neg;

    always_comb begin
        adv_vld = 1'b0;
        adv_x   = pix_x;
        adv_y   = pix_y;
        adv_neg = tick_neg;
        case (state)
            S_CLEAR: begin
                if (pix_x != X_LAST) begin
                    adv_vld = 1'b1;
                    adv_x   = pix_x + 1'b1;
                end else if (pix_y != Y_LAST) begin
                    adv_vld = 1'b1;
                    adv_x   = '0;
                    adv_y   = pix_y + 1'b1;
                end
            end
            S_XAXIS: begin
                if (pix_x != X_LAST) begin
                    adv_vld = 1'b1;
                    adv_x   = pix_x + 1'b1;
                end
            end
            S_YAXIS: begin
                if (pix_y != Y_LAST) begin
                    adv_vld = 1'b1;
                    adv_y   = pix_y + 1'b1;
                end
            end
            S_XTICK: begin
                if (pix_y < xt_row_hi) begin
                    adv_vld = 1'b1;
                    adv_y   = pix_y + 1'b1;
                end else if (!tick_neg && px_p_ok) begin
                    adv_vld = 1'b1;
                    adv_x   = px_p[X_W-1:0];
                    adv_y   = xt_row_lo;
                end else if (!tick_neg && xt_neg_ok) begin
                    // Positive side exhausted: jump to the first tick left of centre.
                    adv_vld = 1'b1;
                    adv_x   = xt_neg[X_W-1:0];
                    adv_y   = xt_row_lo;
                    adv_neg = 1'b1;
                end else if (tick_neg && px_m_ok) begin
                    adv_vld = 1'b1;
                    adv_x   = px_m[X_W-1:0];
                    adv_y   = xt_row_lo;
                end
            end
            S_YTICK: begin
                if (pix_x < yt_col_hi) begin
                    adv_vld = 1'b1;
                    adv_x   = pix_x + 1'b1;
                end else if (!tick_neg && py_p_ok) begin
                    adv_vld = 1'b1;
                    adv_x   = yt_col_lo;
                    adv_y   = py_p[Y_W-1:0];
                end else if (!tick_neg && yt_neg_ok) begin
                    adv_vld = 1'b1;
                    adv_x   = yt_col_lo;
                    adv_y   = yt_neg[Y_W-1:0];
                    adv_neg = 1'b1;
                end else if (tick_neg && py_m_ok) begin
                    adv_vld = 1'b1;
                    adv_x   = yt_col_lo;
                    adv_y   = py_m[Y_W-1:0];
                end
            end
            default: ;
        endcase
    end

    // ---------------------------------------------------------------
    // Next pixel: stay in the phase if it has more, otherwise fall through
    // to the first non-empty later phase so empty phases cost no cycles.
    // ---------------------------------------------------------------
    state_t           n_state;
    logic [X_W-1:0]   n_x;
    logic [Y_W-1:0]   n_y;
    logic             n_neg;
    logic [COL_W-1:0] n_col;
    logic             before_yaxis, before_xtick, before_ytick;

    assign before_yaxis = (state == S_CLEAR) || (state == S_XAXIS);
    assign before_xtick = before_yaxis || (state == S_YAXIS);
    assign before_ytick = before_xtick || (state == S_XTICK);

    always_comb begin
        n_state = S_DONE;
        n_x     = '0;
        n_y     = '0;
        n_neg   = 1'b0;
        if (adv_vld) begin
            n_state = state;
            n_x     = adv_x;
            n_y     = adv_y;
            n_neg   = adv_neg;
        end else if ((state == S_CLEAR) && y_on) begin
            n_state = S_XAXIS;
            n_y     = yc_r;
        end else if (before_yaxis && x_on) begin
            n_state = S_YAXIS;
            n_x     = xc_r;
        end else if (before_xtick && ticks_on && (xt_pos_ok || xt_neg_ok)) begin
            n_state = S_XTICK;
            n_x     = xt_pos_ok ? xt_pos[X_W-1:0] : xt_neg[X_W-1:0];
            n_y     = xt_row_lo;
            n_neg   = !xt_pos_ok;
        end else if (before_ytick && ticks_on && (yt_pos_ok || yt_neg_ok)) begin
            n_state = S_YTICK;
            n_x     = yt_col_lo;
            n_y     = yt_pos_ok ? yt_pos[Y_W-1:0] : yt_neg[Y_W-1:0];
            n_neg   = !yt_pos_ok;
        end
        n_col = (n_state == S_CLEAR) ? bg_r : axis_r;
    end

    // ---------------------------------------------------------------
    // State and registered outputs
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            pix_valid <= 1'b0;
            pix_x     <= '0;
            pix_y     <= '0;
            pix_col   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            tick_neg  <= 1'b0;
            xc_r      <= '0;
            yc_r      <= '0;
            bg_r      <= '0;
            axis_r    <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        xc_r      <= x_center;
                        yc_r      <= y_center;
                        bg_r      <= bg_col;
                        axis_r    <= axis_col;
                        state     <= S_CLEAR;
                        pix_x     <= '0;
                        pix_y     <= '0;
                        pix_col   <= bg_col;
                        pix_valid <= 1'b1;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        tick_neg  <= 1'b0;
                    end
                end
                default: begin
                    // pix_valid is always high in the drawing states.
                    if (pix_ready) begin
                        state    <= n_state;
                        pix_x    <= n_x;
                        pix_y    <= n_y;
                        pix_col  <= n_col;
                        tick_neg <= n_neg;
                        if (n_state == S_DONE) begin
                            pix_valid <= 1'b0;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end

endmodule
